// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage: evaluates B-type conditions, JAL/JALR targets
// and mispredict, through a 1- or 2-stage valid/ready pipe. Option: BRU_PERF_CNT_EN.
module branch_resolve_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            FLUSH,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] RS1V,
  input  logic [XLEN-1:0] RS2V,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] IMM,
  input  logic [2:0]      OP,
  input  logic [1:0]      KIND,
  input  logic            PRED_TAKEN,
  input  logic [XLEN-1:0] PRED_TARGET,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic            TAKEN,
  output logic [XLEN-1:0] TARGET,
  output logic            MISPRED,
  output logic            ILLEGAL
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]     CNT_BRANCH,
  output logic [31:0]     CNT_TAKEN,
  output logic [31:0]     CNT_MISPRED
`endif
);

  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;
  logic            w_taken;
  logic            w_illegal;
  logic            w_jalr;
  logic [XLEN-1:0] w_jmp;
  logic [XLEN-1:0] w_target;
  logic            w_a_ready;
  logic            w_a_load;
  logic            w_a_mispred;

  logic            r_a_valid;
  logic            r_a_taken;
  logic            r_a_illegal;
  logic            r_a_pred_taken;
  logic [XLEN-1:0] r_a_target;
  logic [XLEN-1:0] r_a_pred_target;

  assign w_eq   = RS1V == RS2V;
  assign w_lt   = $signed(RS1V) < $signed(RS2V);
  assign w_ltu  = RS1V < RS2V;
  assign w_jalr = KIND == 2'b11;
  assign w_jmp  = (w_jalr ? RS1V : PC) + IMM;

  // Direction and reserved-funct3 detection
  always_comb begin
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    unique case (KIND)
      2'b01: begin
        unique case (OP)
          3'b000:  w_taken = w_eq;
          3'b001:  w_taken = !w_eq;
          3'b100:  w_taken = w_lt;
          3'b101:  w_taken = !w_lt;
          3'b110:  w_taken = w_ltu;
          3'b111:  w_taken = !w_ltu;
          default: w_illegal = 1'b1;
        endcase
      end
      2'b10, 2'b11: w_taken = 1'b1;
      default:      w_taken = 1'b0;
    endcase
  end

  assign w_target = !w_taken ? PC + XLEN'(4)
                  : w_jalr   ? {w_jmp[XLEN-1:1], 1'b0}
                  : w_jmp;

  assign IN_READY = w_a_ready;
  assign w_a_load = w_a_ready & IN_VALID;

  assign w_a_mispred = (r_a_taken != r_a_pred_taken)
                     | (r_a_taken & (r_a_target != r_a_pred_target));

  // Stage A: register direction, target and prediction
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a_valid       <= 1'b0;
      r_a_taken       <= 1'b0;
      r_a_illegal     <= 1'b0;
      r_a_pred_taken  <= 1'b0;
      r_a_target      <= '0;
      r_a_pred_target <= '0;
    end else begin
      if (FLUSH)
        r_a_valid <= 1'b0;
      else if (w_a_ready)
        r_a_valid <= IN_VALID;
      if (w_a_load) begin
        r_a_taken       <= w_taken;
        r_a_illegal     <= w_illegal;
        r_a_pred_taken  <= PRED_TAKEN;
        r_a_target      <= w_target;
        r_a_pred_target <= PRED_TARGET;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  logic r_a_br;
  logic w_out_br;
  logic w_xfer;

  // Stage A: remember whether the entry is a control-flow op
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_a_br <= 1'b0;
    else if (w_a_load)
      r_a_br <= KIND != 2'b00;
  end
`endif

  generate
    if (STAGES == 2) begin : g_two
      logic            r_b_valid;
      logic            r_b_taken;
      logic            r_b_illegal;
      logic            r_b_mispred;
      logic [XLEN-1:0] r_b_target;
      logic            w_b_ready;

      assign w_b_ready = !r_b_valid | OUT_READY;
      assign w_a_ready = !r_a_valid | w_b_ready;

      // Stage B: register mispredict and hold result for the consumer
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_b_valid   <= 1'b0;
          r_b_taken   <= 1'b0;
          r_b_illegal <= 1'b0;
          r_b_mispred <= 1'b0;
          r_b_target  <= '0;
        end else begin
          if (FLUSH)
            r_b_valid <= 1'b0;
          else if (w_b_ready)
            r_b_valid <= r_a_valid;
          if (w_b_ready && r_a_valid) begin
            r_b_taken   <= r_a_taken;
            r_b_illegal <= r_a_illegal;
            r_b_mispred <= w_a_mispred;
            r_b_target  <= r_a_target;
          end
        end
      end

      assign OUT_VALID = r_b_valid;
      assign TAKEN     = r_b_taken;
      assign TARGET    = r_b_target;
      assign MISPRED   = r_b_mispred;
      assign ILLEGAL   = r_b_illegal;

`ifdef BRU_PERF_CNT_EN
      logic r_b_br;

      // Stage B: carry the control-flow flag alongside the result
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
          r_b_br <= 1'b0;
        else if (w_b_ready && r_a_valid)
          r_b_br <= r_a_br;
      end

      assign w_out_br = r_b_br;
`endif
    end else begin : g_one
      assign w_a_ready = !r_a_valid | OUT_READY;
      assign OUT_VALID = r_a_valid;
      assign TAKEN     = r_a_taken;
      assign TARGET    = r_a_target;
      assign MISPRED   = w_a_mispred;
      assign ILLEGAL   = r_a_illegal;
`ifdef BRU_PERF_CNT_EN
      assign w_out_br  = r_a_br;
`endif
    end
  endgenerate

`ifdef BRU_PERF_CNT_EN
  assign w_xfer = OUT_VALID & OUT_READY & !FLUSH;

  // Event counters on each delivered result
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CNT_BRANCH  <= '0;
      CNT_TAKEN   <= '0;
      CNT_MISPRED <= '0;
    end else if (w_xfer) begin
      if (w_out_br) CNT_BRANCH  <= CNT_BRANCH + 32'd1;
      if (TAKEN)    CNT_TAKEN   <= CNT_TAKEN + 32'd1;
      if (MISPRED)  CNT_MISPRED <= CNT_MISPRED + 32'd1;
    end
  end
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, pipelined branch/jump resolution stage for the RV32/RV64 core.
- Takes decoded branch operands plus the fetch-stage prediction and evaluates all six RISC-V B-type conditions, signed and unsigned, as well as JAL/JALR.
- Produces the taken flag, the resolved target and a mispredict/redirect indication through a registered valid/ready pipeline.
- Sits between the register-read and execute stages and drives the fetch redirect path.

Parameters:
- XLEN, 32, operand, PC and immediate width (32 or 64).
- STAGES, 1, pipeline depth in registered stages (1 or 2); with 2, compare and target are computed in stage 1 and mispredict in stage 2.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  reset; one clock, reset is asynchronous and active-low.
- FLUSH  in  1  synchronous kill of all in-flight entries.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  unit can accept a request this cycle.
- RS1V  in  XLEN  source operand 1.
- RS2V  in  XLEN  source operand 2.
- PC  in  XLEN  PC of the branch.
- IMM  in  XLEN  sign-extended immediate.
- OP  in  3  funct3.
- KIND  in  2  00 none, 01 branch, 10 JAL, 11 JALR.
- PRED_TAKEN  in  1  fetch prediction.
- PRED_TARGET  in  XLEN  predicted target.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts the result.
- TAKEN  out  1  resolved direction.
- TARGET  out  XLEN  resolved next PC.
- MISPRED  out  1  redirect required.
- ILLEGAL  out  1  reserved funct3 on a branch.

Behaviour:
- Reset: all stage valid bits are 0; OUT_VALID, TAKEN, MISPRED and ILLEGAL are 0; TARGET is 0. IN_READY is 1 once reset is released.
- Condition by OP when KIND=01:
  - 000: equal.
  - 001: not equal.
  - 100: signed less-than.
  - 101: signed greater-or-equal.
  - 110: unsigned less-than.
  - 111: unsigned greater-or-equal.
  - 010 and 011: not taken, ILLEGAL=1.
- KIND=10 or 11: TAKEN=1 regardless of OP.
- KIND=00: TAKEN=0, ILLEGAL=0.
- TARGET when TAKEN=1:
  - Branch and JAL: PC+IMM.
  - JALR: (RS1V+IMM) with bit 0 cleared.
- TARGET when TAKEN=0: PC+4.
- All additions are modulo 2^XLEN; wrap-around is silent.
- MISPRED = (TAKEN != PRED_TAKEN) OR (TAKEN AND TARGET != PRED_TARGET).
- Latency: request accepted at edge N gives OUT_VALID at edge N+STAGES.
- Handshake:
  - A transfer occurs on a cycle with VALID & READY high.
  - IN_READY = !last_stage_valid | OUT_READY, propagated stage by stage; a stage advances only if the next stage is empty or advancing.
  - While OUT_VALID=1 and OUT_READY=0, all outputs hold stable.
  - One result per cycle at full throughput.
- FLUSH: at the next edge every stage valid bit clears and OUT_VALID drops. A request presented in the same cycle as FLUSH is dropped. FLUSH overrides a simultaneous output transfer; the consumer treats that result as killed.
- Reset asserted mid-operation: in-flight entries are lost immediately and outputs return to their reset values asynchronously.
- Data registers may hold stale values when their valid bit is 0; checkers sample outputs only when OUT_VALID=1.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- When defined, adds three outputs: CNT_BRANCH (32), CNT_TAKEN (32) and CNT_MISPRED (32).
  - Counts are taken on the output transfer (OUT_VALID & OUT_READY & !FLUSH).
  - CNT_BRANCH counts KIND!=00; CNT_TAKEN counts TAKEN; CNT_MISPRED counts MISPRED.
  - Counters wrap at 2^32, clear on reset and are unaffected by FLUSH.
- When undefined, the ports and logic are absent.

Test Plan:
- Signed vs unsigned: RS1V=0xFFFFFFFF, RS2V=1, KIND=01. OP=100 gives TAKEN=1; OP=110 gives TAKEN=0; OP=111 gives TAKEN=1. PC=0x100, IMM=0x20 gives TARGET 0x120 when taken, 0x104 when not.
- JALR/mispredict: KIND=11, RS1V=0x1001, IMM=4, PRED_TAKEN=1, PRED_TARGET=0x1004 gives TARGET=0x1004, MISPRED=0. With PRED_TARGET=0x1008, MISPRED=1.
- Backpressure: STAGES=2, issue 4 back-to-back requests with OUT_READY=0. Expect IN_READY low after 2 accepts and outputs frozen. Raise OUT_READY: results emerge in order, one per cycle.
- Flush: 2 entries in flight, FLUSH=1 with IN_VALID=1. Next cycle OUT_VALID=0, and the new request never appears at the output.
- Boundary/illegal: PC=0xFFFFFFFC, IMM=8, BEQ equal gives TARGET=0x4. OP=010 gives TAKEN=0, ILLEGAL=1, TARGET=PC+4.
- Async reset/counters: assert RST_N low mid-stream between edges. OUT_VALID drops immediately. With BRU_PERF_CNT_EN, counters read 0; after 3 taken branches of which 1 is mispredicted, counters read 3/3/1.
